// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts for a sync byte in the UART byte stream, assembles
// the block-header payload, checks the trailing XOR checksum, and hands the
// verified header to the hashing core. Checksum, timeout and overrun errors
// are flagged on a one-cycle strobe with a sticky code.
//
// Output handshake: o_frame_vld is raised with ov_frame_data when a verified
// frame is loaded and is held, with the data stable, until a cycle where
// o_frame_vld && i_frame_rdy (the transfer). The slot counts as free in a
// transfer cycle, so a new frame may be loaded in that same cycle.
module uart_frame_parser #(
    parameter string IS_SIM            = "TRUE",
    parameter int    UART_DATA_WID     = 8,
    parameter int    FRAME_BYTE_NUM    = 82,
    parameter logic [UART_DATA_WID-1:0] SYNC_BYTE = 8'h55,
    parameter int    TIMEOUT_CNT_NUM   = (IS_SIM == "TRUE") ? 200 : 100000,
    parameter int    PAYLOAD_WID       = (FRAME_BYTE_NUM - 2) * UART_DATA_WID
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [UART_DATA_WID-1:0] iv_rx_data,
    input  logic                     i_rx_data_vld,
    output logic [PAYLOAD_WID-1:0]   ov_frame_data,
    output logic                     o_frame_vld,
    input  logic                     i_frame_rdy,
    output logic                     o_frame_err,
    output logic [1:0]               ov_err_code,
    output logic [1:0]               dbg_state
);

    localparam int TO_W   = $clog2(TIMEOUT_CNT_NUM);
    localparam int BCNT_W = $clog2(FRAME_BYTE_NUM);

    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CNT_NUM - 1);
    localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(FRAME_BYTE_NUM - 3);

    localparam logic [1:0] ERR_CHKSUM  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [BCNT_W-1:0]        byte_cnt;
    logic [TO_W-1:0]          to_cnt;
    logic [UART_DATA_WID-1:0] xor_acc;
    logic [PAYLOAD_WID-1:0]   asm_reg;

    logic       start_frame;
    logic       shift_en;
    logic       load_frame;
    logic       err_set;
    logic [1:0] err_code_nxt;
    logic       slot_free;

    assign dbg_state = state;
    assign slot_free = !o_frame_vld || i_frame_rdy;

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt    = state;
        start_frame  = 1'b0;
        shift_en     = 1'b0;
        load_frame   = 1'b0;
        err_set      = 1'b0;
        err_code_nxt = ov_err_code;
        case (state)
            ST_IDLE: begin
                if (i_rx_data_vld && (iv_rx_data == SYNC_BYTE)) begin
                    start_frame = 1'b1;
                    state_nxt   = ST_RECV;
                end
            end
            ST_RECV: begin
                if (i_rx_data_vld) begin
                    shift_en = 1'b1;
                    if (byte_cnt == BYTE_LAST) begin
                        state_nxt = ST_CHK;
                    end
                end else if (to_cnt == TO_LAST) begin
                    state_nxt    = ST_IDLE;
                    err_set      = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            ST_CHK: begin
                if (i_rx_data_vld) begin
                    state_nxt = ST_IDLE;
                    if (iv_rx_data != xor_acc) begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_CHKSUM;
                    end else if (slot_free) begin
                        load_frame = 1'b1;
                    end else begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_OVERRUN;
                    end
                end else if (to_cnt == TO_LAST) begin
                    state_nxt    = ST_IDLE;
                    err_set      = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Byte counter, running checksum and payload assembly register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            xor_acc  <= '0;
            asm_reg  <= '0;
        end else if (start_frame) begin
            byte_cnt <= '0;
            xor_acc  <= '0;
        end else if (shift_en) begin
            byte_cnt <= byte_cnt + BCNT_W'(1);
            xor_acc  <= xor_acc ^ iv_rx_data;
            asm_reg  <= {asm_reg[PAYLOAD_WID-UART_DATA_WID-1:0], iv_rx_data};
        end
    end

    // Inter-byte idle counter; only meaningful while a frame is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if ((state == ST_IDLE) || i_rx_data_vld || (state_nxt == ST_IDLE)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Output slot: load on a verified frame, release on transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_frame_data <= '0;
            o_frame_vld   <= 1'b0;
        end else if (load_frame) begin
            ov_frame_data <= asm_reg;
            o_frame_vld   <= 1'b1;
        end else if (i_frame_rdy) begin
            o_frame_vld   <= 1'b0;
        end
    end

    // Error strobe with a code that persists until the next error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_frame_err <= 1'b0;
            ov_err_code <= 2'b00;
        end else begin
            o_frame_err <= err_set;
            if (err_set) begin
                ov_err_code <= err_code_nxt;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed scenarios plus randomized frames;
// expected frames/errors are queued by the stimulus and consumed by a monitor.
module tb_uart_frame_parser;

    localparam int PW = 640;
    localparam int NP = 80;
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    iv_rx_data;
    logic          i_rx_data_vld;
    logic [PW-1:0] ov_frame_data;
    logic          o_frame_vld;
    logic          i_frame_rdy;
    logic          o_frame_err;
    logic [1:0]    ov_err_code;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] exp_frame_q[$];
    logic [1:0]    exp_err_q[$];

    logic [7:0]    pl[NP];

    uart_frame_parser #(.IS_SIM("TRUE")) dut (
        .clk           (clk),
        .rst           (rst),
        .iv_rx_data    (iv_rx_data),
        .i_rx_data_vld (i_rx_data_vld),
        .ov_frame_data (ov_frame_data),
        .o_frame_vld   (o_frame_vld),
        .i_frame_rdy   (i_frame_rdy),
        .o_frame_err   (o_frame_err),
        .ov_err_code   (ov_err_code),
        .dbg_state     (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // reference model helpers
    function automatic logic [PW-1:0] model_pack();
        logic [PW-1:0] d;
        d = '0;
        for (int i = 0; i < NP; i++) d[PW-1-8*i -: 8] = pl[i];
        return d;
    endfunction

    function automatic logic [7:0] model_xor();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < NP; i++) x = x ^ pl[i];
        return x;
    endfunction

    // driver: optional idle cycles, then one byte strobe; starts/ends at posedge+1
    task automatic drive_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        iv_rx_data    = b;
        i_rx_data_vld = 1'b1;
        @(posedge clk);
        #1;
        i_rx_data_vld = 1'b0;
        iv_rx_data    = $urandom_range(0, 255);
    endtask

    // full frame from pl[], with expectation pushed before the checksum byte
    task automatic send_frame(input logic [7:0] chk, input bit raise_rdy, input int max_gap);
        drive_byte(8'h55, $urandom_range(0, max_gap));
        for (int i = 0; i < NP; i++) drive_byte(pl[i], $urandom_range(0, max_gap));
        if (chk != model_xor())
            exp_err_q.push_back(2'b01);
        else if (exp_frame_q.size() != 0 && !(i_frame_rdy || raise_rdy))
            exp_err_q.push_back(2'b11);
        else
            exp_frame_q.push_back(model_pack());
        if (raise_rdy) i_frame_rdy = 1'b1;
        drive_byte(chk, $urandom_range(0, max_gap));
    endtask

    task automatic fill_counting();
        for (int i = 0; i < NP; i++) pl[i] = 8'(i + 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NP; i++) pl[i] = 8'($urandom_range(0, 255));
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (o_frame_err) begin
                if (exp_err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL err_unexpected actual=code %0b required=no error", ov_err_code);
                end else begin
                    check("err_code", PW'(ov_err_code), PW'(exp_err_q.pop_front()));
                end
            end
            if (o_frame_vld && i_frame_rdy) begin
                if (exp_frame_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected actual=%0h required=no frame", ov_frame_data);
                end else begin
                    check("frame_data", ov_frame_data, exp_frame_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        logic [7:0] b;
        logic [PW-1:0] held;

        rst           = 1'b1;
        iv_rx_data    = 8'h00;
        i_rx_data_vld = 1'b0;
        i_frame_rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_vld",  PW'(o_frame_vld),   '0);
        check("reset_err",  PW'(o_frame_err),   '0);
        check("reset_code", PW'(ov_err_code),   '0);
        check("reset_data", ov_frame_data,      '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // good frame, back-to-back bytes
        fill_counting();
        send_frame(model_xor(), 1'b0, 0);
        check("good_vld_latency", PW'(o_frame_vld), PW'(1));
        check("good_msb", PW'(ov_frame_data[639:632]), PW'(8'h01));
        check("good_lsb", PW'(ov_frame_data[7:0]),     PW'(8'h50));
        @(posedge clk);
        #1;
        check("good_vld_clear", PW'(o_frame_vld), '0);

        // leading garbage then good frame, then bad checksum
        drive_byte(8'hAA, 1);
        drive_byte(8'h00, 0);
        send_frame(model_xor(), 1'b0, 1);
        repeat (3) @(posedge clk);
        #1;
        send_frame(8'h51, 1'b0, 0);
        check("bad_err",  PW'(o_frame_err), PW'(1));
        check("bad_code", PW'(ov_err_code), PW'(2'b01));
        check("bad_vld",  PW'(o_frame_vld), '0);

        // timeout after 10 payload bytes
        drive_byte(8'h55, 2);
        for (int i = 0; i < 10; i++) drive_byte(8'(i + 8'h10), 0);
        exp_err_q.push_back(2'b10);
        n = 0;
        for (int k = 1; k <= TO + 50; k++) begin
            @(posedge clk);
            #1;
            if (o_frame_err) begin
                n = k;
                break;
            end
        end
        check("timeout_cycles", PW'(n), PW'(TO));
        check("timeout_code",   PW'(ov_err_code), PW'(2'b10));
        fill_counting();
        send_frame(model_xor(), 1'b0, 0);
        check("after_timeout_vld", PW'(o_frame_vld), PW'(1));

        // overrun: consumer stalled across two good frames
        repeat (2) @(posedge clk);
        #1;
        i_frame_rdy = 1'b0;
        fill_random();
        held = model_pack();
        send_frame(model_xor(), 1'b0, 0);
        fill_random();
        send_frame(model_xor(), 1'b0, 1);
        check("overrun_err",  PW'(o_frame_err), PW'(1));
        check("overrun_code", PW'(ov_err_code), PW'(2'b11));
        check("overrun_held", ov_frame_data, held);
        i_frame_rdy = 1'b1;
        @(posedge clk);
        #1;
        i_frame_rdy = 1'b0;

        // accept and reload in the same cycle
        fill_random();
        send_frame(model_xor(), 1'b0, 0);
        fill_random();
        send_frame(model_xor(), 1'b1, 0);
        check("swap_vld",  PW'(o_frame_vld), PW'(1));
        check("swap_data", ov_frame_data, model_pack());
        @(posedge clk);
        #1;

        // reset mid-frame with a held frame and a sticky code
        i_frame_rdy = 1'b0;
        fill_random();
        send_frame(model_xor(), 1'b0, 0);
        drive_byte(8'h00, 0);
        fill_counting();
        drive_byte(8'h55, 0);
        for (int i = 0; i < 40; i++) drive_byte(pl[i], 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_vld",  PW'(o_frame_vld), '0);
        check("rst_err",  PW'(o_frame_err), '0);
        check("rst_code", PW'(ov_err_code), '0);
        check("rst_data", ov_frame_data,    '0);
        exp_frame_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        i_frame_rdy = 1'b1;
        for (int i = 40; i < NP; i++) drive_byte(pl[i], 0);
        drive_byte(model_xor(), 0);
        check("rst_tail_vld", PW'(o_frame_vld), '0);
        fill_counting();
        send_frame(model_xor(), 1'b0, 0);
        check("rst_fresh_vld", PW'(o_frame_vld), PW'(1));

        // randomized frames with garbage, gaps and occasional bad checksums
        for (int f = 0; f < 8; f++) begin
            for (int g = 0; g < $urandom_range(0, 3); g++) begin
                do b = 8'($urandom_range(0, 255)); while (b == 8'h55);
                drive_byte(b, $urandom_range(0, 2));
            end
            fill_random();
            if ($urandom_range(0, 3) == 0)
                send_frame(model_xor() ^ 8'($urandom_range(1, 255)), 1'b0, 2);
            else
                send_frame(model_xor(), 1'b0, 2);
        end

        repeat (5) @(posedge clk);
        #1;
        check("frames_left", PW'(exp_frame_q.size()), '0);
        check("errs_left",   PW'(exp_err_q.size()),   '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
